// File: rtl/sh_reg_if.sv
// -----------------------------------------------------------------------------
// sh_reg_if -- bus bundle for the branch-history shift register.
//
// Signals:
//   wr_en    shift-enable: shift wr_data into the history
//   wr_data  outcome bit to shift in (1 = taken, 0 = not taken)
//   re_en    restore-enable: overwrite the history with re_data
//   re_data  restore value (checkpointed history) [WIDTH]
//   rd_data  current history contents             [WIDTH]
//
// Modports:
//   master  the predictor side; drives updates, observes the history
//   slave   the history register itself
// -----------------------------------------------------------------------------
interface sh_reg_if #(
  parameter int WIDTH = 14
);

  logic             wr_en;
  logic             wr_data;
  logic             re_en;
  logic [WIDTH-1:0] re_data;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en,
    output wr_data,
    output re_en,
    output re_data,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  re_en,
    input  re_data,
    output rd_data
  );

endinterface : sh_reg_if

// File: rtl/sh_reg.sv
// -----------------------------------------------------------------------------
// sh_reg -- global branch-history shift register with checkpoint restore.
//
// Holds a WIDTH-bit history. Each rising clk edge does exactly one of:
//   reset   (async, active-high)  -> history cleared to 0
//   re_en=1                       -> history loaded from re_data
//   wr_en=1                       -> history shifted left, wr_data in at LSB
//   otherwise                     -> history held
// rd_data is the history register itself: updates become visible right
// after the edge that applied them, never combinationally from the inputs.
//
// Ports:
//   clk    input   sole clock, rising-edge active
//   reset  input   asynchronous, active-high reset
//   bus    sh_reg_if.slave  wr_en/wr_data/re_en/re_data in, rd_data out
// -----------------------------------------------------------------------------
module sh_reg #(
  parameter int WIDTH = 14
) (
  input  logic    clk,
  input  logic    reset,
  sh_reg_if.slave bus
);

  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;
  logic [WIDTH-1:0] hist_shifted;

  // Left shift with the new outcome entering at the LSB; the old MSB falls
  // off silently. A one-bit history degenerates to just the newest outcome.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign hist_shifted = bus.wr_data;
    end else begin : g_shift_wn
      assign hist_shifted = {hist_q[WIDTH-2:0], bus.wr_data};
    end
  endgenerate

  // Restore outranks shift: a misprediction recovery must not be polluted by
  // an outcome bit from the squashed path arriving on the same edge.
  always_comb begin
    // NOTE: default first so every path assigns hist_d -- no latch inferred.
    hist_d = hist_q;
    if (bus.re_en) begin
      hist_d = bus.re_data;
    end else if (bus.wr_en) begin
      hist_d = hist_shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      hist_q <= hist_d;
    end
  end

  assign bus.rd_data = hist_q;

endmodule : sh_reg

// File: tb/tb_sh_reg.sv
// -----------------------------------------------------------------------------
// tb_sh_reg -- directed, table-driven bench for sh_reg (WIDTH = 14).
// -----------------------------------------------------------------------------
module tb_sh_reg;

  localparam int WIDTH = 14;
  localparam int NVEC  = 20;

  logic clk;
  logic reset;

  int checks;
  int errors;

  sh_reg_if #(.WIDTH(WIDTH)) bus ();

  sh_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             re_en;
    logic [WIDTH-1:0] re_data;
    logic             wr_en;
    logic             wr_data;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Present inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic re_en, input logic [WIDTH-1:0] re_data,
                       input logic wr_en, input logic wr_data);
    @(negedge clk);
    bus.re_en   = re_en;
    bus.re_data = re_data;
    bus.wr_en   = wr_en;
    bus.wr_data = wr_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //                re_en  re_data   wr_en wr_data expected
    vecs[0]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0001};  // shift 1
    vecs[1]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0002};  // shift 0
    vecs[2]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0005};  // shift 1
    vecs[3]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h000B};  // shift 1
    vecs[4]  = '{1'b1, 14'h2CB9, 1'b0, 1'b0, 14'h2CB9};  // restore
    vecs[5]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h1972};  // shift 0
    vecs[6]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h32E5};  // shift 1
    vecs[7]  = '{1'b1, 14'h3FFF, 1'b0, 1'b0, 14'h3FFF};  // restore all ones
    vecs[8]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h3FFE};  // MSB dropped
    vecs[9]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h3FFE};  // hold
    vecs[10] = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h3FFE};  // hold
    vecs[11] = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h3FFE};  // hold
    vecs[12] = '{1'b1, 14'h0001, 1'b1, 1'b1, 14'h0001};  // restore beats shift
    vecs[13] = '{1'b0, 14'h1555, 1'b0, 1'b1, 14'h0001};  // hold, wr_data ignored
    vecs[14] = '{1'b1, 14'h2000, 1'b1, 1'b0, 14'h2000};  // restore beats shift
    vecs[15] = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0001};  // MSB wraps out
    vecs[16] = '{1'b1, 14'h0000, 1'b0, 1'b1, 14'h0000};  // restore to zero
    vecs[17] = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0001};  // shift 1
    vecs[18] = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0003};  // shift 1
    vecs[19] = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0006};  // shift 0

    // Reset with no clock edge seen yet: output must clear immediately.
    reset       = 1'b1;
    bus.re_en   = 1'b0;
    bus.re_data = '0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 1'b1;
    #2;
    check("reset_no_edge", bus.rd_data, 14'h0000);

    // Held reset ignores shifts and restores across several edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_shift", bus.rd_data, 14'h0000);
    @(negedge clk);
    bus.re_en   = 1'b1;
    bus.re_data = 14'h3FFF;
    @(posedge clk);
    #1;
    check("reset_held_restore", bus.rd_data, 14'h0000);

    @(negedge clk);
    reset     = 1'b0;
    bus.re_en = 1'b0;
    bus.wr_en = 1'b0;
    check("reset_release", bus.rd_data, 14'h0000);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].re_en, vecs[i].re_data, vecs[i].wr_en, vecs[i].wr_data);
      check($sformatf("vec%0d", i), bus.rd_data, vecs[i].exp);
    end

    // No combinational path: a restore presented mid-cycle is invisible
    // until the edge.
    @(negedge clk);
    bus.re_en   = 1'b1;
    bus.re_data = 14'h1234;
    bus.wr_en   = 1'b0;
    #1;
    check("no_bypass", bus.rd_data, 14'h0006);
    @(posedge clk);
    #1;
    check("restore_after_edge", bus.rd_data, 14'h1234);

    // A pulse that is gone by the edge must have no effect.
    @(negedge clk);
    bus.re_en   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 1'b1;
    #1;
    bus.wr_en   = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_ignored", bus.rd_data, 14'h1234);

    // Asynchronous reset mid-operation with a shift pending.
    drive(1'b1, 14'h2CB9, 1'b0, 1'b0);
    check("pre_async_reset", bus.rd_data, 14'h2CB9);
    bus.re_en   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_now", bus.rd_data, 14'h0000);
    @(posedge clk);
    #1;
    check("async_reset_edge", bus.rd_data, 14'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_shift_after_reset", bus.rd_data, 14'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sh_reg
